// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU data port (master) and the responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  error;

  modport master (
    output req_valid, mem_read, mem_write, address, write_data,
    input  req_ready, resp_valid, read_data, error
  );

  modport slave (
    input  req_valid, mem_read, mem_write, address, write_data,
    output req_ready, resp_valid, read_data, error
  );

endinterface

// File: rtl/data_mem_responder_word_array.sv
// Word storage: synchronous write, combinational read, zero at time 0 and untouched by reset.
module mem_word_array #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accept one request, wait WAIT_CYCLES, then
// commit the access and pulse resp_valid for one cycle.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int MEM_BYTES = DEPTH_WORDS * WORD_BYTES;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  req_err;
  logic                  commit;
  logic                  mem_we;
  logic [IDX_W-1:0]      cur_idx;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  cur_write;
  logic                  cur_err;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign accept  = bus.req_valid && (state_q == IDLE) && (bus.mem_read || bus.mem_write);
  assign req_err = (bus.address[ADDR_LSB-1:0] != '0)
                || (bus.address >= 32'(MEM_BYTES))
                || (bus.mem_read && bus.mem_write);

  // With WAIT_CYCLES=0 the access commits on the accept edge, so use the live request.
  assign cur_idx   = (state_q == IDLE) ? bus.address[ADDR_LSB +: IDX_W] : idx_q;
  assign cur_wdata = (state_q == IDLE) ? bus.write_data : wdata_q;
  assign cur_write = (state_q == IDLE) ? bus.mem_write : write_q;
  assign cur_err   = (state_q == IDLE) ? req_err : err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    error_d = error_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = bus.address[ADDR_LSB +: IDX_W];
          wdata_d = bus.write_data;
          write_d = bus.mem_write;
          err_d   = req_err;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rdata_d = (cur_write || cur_err) ? '0 : mem_rdata;
      error_d = cur_err;
    end
  end

  // A reset coinciding with the commit edge must abandon the store.
  assign mem_we = commit && cur_write && !cur_err && !reset;

  mem_word_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .raddr_i (cur_idx),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.read_data  = rdata_q;
  assign bus.error      = error_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the CPU data-memory interface. It accepts one read or write request at a time over a valid/ready handshake and waits a fixed number of cycles to model memory latency. It then performs the access on internal word storage and returns a one-cycle response pulse carrying read data or an error flag. It replaces the zero-latency data memory when the multi-cycle CPU is evaluated.

Parameters:
DATA_WIDTH, 32, word width in bits
DEPTH_WORDS, 256, number of words stored; valid byte addresses are 0 to DEPTH_WORDS*4-1
WAIT_CYCLES, 2, extra cycles between request accept and response (0 allowed)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
mem_read  in  1  request is a read (sampled with req_valid)
mem_write  in  1  request is a write (sampled with req_valid)
address  in  32  byte address (word aligned)
write_data  in  DATA_WIDTH  store data
resp_valid  out  1  one-cycle response pulse
read_data  out  DATA_WIDTH  load result, valid when resp_valid=1
error  out  1  request rejected, valid when resp_valid=1

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE, req_ready=1, resp_valid=0, read_data=0, error=0, wait counter=0.
- Memory contents are not cleared by reset. The storage initialises to zero at time 0.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0, counter counts down.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle.
- Accept: a request is accepted when req_valid=1 and req_ready=1 and (mem_read|mem_write)=1. At accept, address, write_data, op and the error check result are latched.
- req_valid=1 with mem_read=mem_write=0 is not accepted. The responder stays in IDLE.
- Transition after accept: if WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: when counter=0, go to RESP; otherwise decrement the counter.
- RESP: go back to IDLE. The memory access commits on the WAIT->RESP or IDLE->RESP edge:
  - write: store word[address[31:2]] and drive read_data=0;
  - read: read_data=word[address[31:2]].
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- Error cases (checked at accept; error=1 with resp_valid; no storage write; read_data=0):
  - address[1:0]!=0 (misaligned);
  - address >= DEPTH_WORDS*4 (out of range);
  - mem_read=mem_write=1 (both asserted).
- Timing and response are otherwise unchanged for error requests.
- Request inputs are ignored outside IDLE. The initiator must hold them only for the accept cycle.
- Reset mid-operation: the pending request is abandoned, a latched write is not committed, and the block returns to IDLE the cycle after reset.
- read_data and error hold their last value after the RESP cycle but are only meaningful while resp_valid=1.
- Read-after-write: a read accepted after a write's RESP cycle returns the new data.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - constant WORD_BYTES=4;
  - constant ADDR_LSB=2.
- Sub-module mem_word_array (DEPTH_WORDS x DATA_WIDTH):
  - synchronous write on we;
  - combinational read on word index.
- data_mem_responder holds the FSM, wait counter, request latches and error check.

Test Plan:
- Reset, then write addr 0x10 data 0xDEADBEEF, then read 0x10 (WAIT_CYCLES=2) -> each resp_valid 3 cycles after its accept; read_data=0xDEADBEEF, error=0.
- Read 0x13 (misaligned), then read 0x400 (out of range, DEPTH 256) -> error=1, read_data=0; a later read of 0x10 still returns 0xDEADBEEF.
- req_valid=1 with mem_read=mem_write=1 -> error=1. req_valid=1 with both 0 -> no accept, req_ready stays 1, no resp_valid.
- Write 0x20 data 0x12345678, assert reset for 1 cycle during WAIT, then read 0x20 -> returns 0x00000000; resp_valid=0 during the reset cycle.
- WAIT_CYCLES=0 build, back-to-back requests held valid -> accepts every 2nd cycle, resp_valid the cycle after each accept, req_ready=0 in the RESP cycle.
- Write the last word 0x3FC data 0xFFFFFFFF, then read it -> read_data=0xFFFFFFFF, error=0 (upper boundary).
